// File: rtl/processador_param.sv
// Parametrised accumulator processor: writable program memory, ACC/B datapath, flags, jumps, output port.
// Two cycles per instruction (FETCH + EXEC); program writes and start accepted only when idle or halted.
module processador_param #(
  parameter int DATA_W = 4,
  parameter int PC_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              prog_we,
  input  logic [PC_W-1:0]   prog_addr,
  input  logic [DATA_W+3:0] prog_data,
  output logic [DATA_W-1:0] acc,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic [PC_W-1:0]   pc,
  output logic              flag_z,
  output logic              flag_c,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

  localparam logic [3:0] OP_NOP = 4'h0, OP_LDA = 4'h1, OP_LDI = 4'h2, OP_LDB = 4'h3,
                         OP_ADD = 4'h4, OP_SUB = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7,
                         OP_XOR = 4'h8, OP_NOT = 4'h9, OP_SHL = 4'hA, OP_SHR = 4'hB,
                         OP_JMP = 4'hC, OP_JZ  = 4'hD, OP_OUT = 4'hE, OP_HLT = 4'hF;

  state_t            state, state_nxt;
  logic [DATA_W+3:0] mem [2**PC_W];
  logic [DATA_W+3:0] ir;
  logic [DATA_W-1:0] b_reg;

  logic [3:0]        op;
  logic [DATA_W-1:0] imm;
  logic [PC_W-1:0]   jmp_tgt;
  logic [DATA_W:0]   sum, diff;
  logic              can_load, launch;

  logic [DATA_W-1:0] acc_nxt, b_nxt;
  logic [PC_W-1:0]   pc_nxt;
  logic              z_nxt, c_nxt, out_en;

  assign op       = ir[DATA_W+3:DATA_W];
  assign imm      = ir[DATA_W-1:0];
  assign jmp_tgt  = PC_W'(imm);
  assign can_load = (state == S_IDLE) || (state == S_HALT);
  assign launch   = can_load && start;
  assign sum      = {1'b0, acc} + {1'b0, b_reg};
  assign diff     = {1'b0, acc} - {1'b0, b_reg};

  // Program memory has no reset so a loaded program survives a reset.
  always_ff @(posedge clk) begin
    if (prog_we && can_load)
      mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_EXEC;
      S_EXEC:  state_nxt = (op == OP_HLT) ? S_HALT : S_FETCH;
      S_HALT:  if (start) state_nxt = S_FETCH;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == S_FETCH) || (state == S_EXEC);
    halted = (state == S_HALT);
  end

  always_comb begin
    acc_nxt = acc;
    b_nxt   = b_reg;
    z_nxt   = flag_z;
    c_nxt   = flag_c;
    pc_nxt  = pc + PC_W'(1);
    out_en  = 1'b0;
    case (op)
      OP_LDA: acc_nxt = imm;
      OP_LDI: acc_nxt = in_a;
      OP_LDB: b_nxt   = in_b;
      OP_ADD: begin acc_nxt = sum[DATA_W-1:0];  c_nxt = sum[DATA_W];  end
      OP_SUB: begin acc_nxt = diff[DATA_W-1:0]; c_nxt = diff[DATA_W]; end
      OP_AND: acc_nxt = acc & b_reg;
      OP_OR:  acc_nxt = acc | b_reg;
      OP_XOR: acc_nxt = acc ^ b_reg;
      OP_NOT: acc_nxt = ~acc;
      OP_SHL: begin acc_nxt = {acc[DATA_W-2:0], 1'b0}; c_nxt = acc[DATA_W-1]; end
      OP_SHR: begin acc_nxt = {1'b0, acc[DATA_W-1:1]}; c_nxt = acc[0];        end
      OP_JMP: pc_nxt = jmp_tgt;
      OP_JZ:  if (flag_z) pc_nxt = jmp_tgt;
      OP_OUT: out_en = 1'b1;
      default: ;
    endcase
    // Z tracks every opcode that writes ACC, including those that leave it unchanged in value.
    if (op == OP_LDA || op == OP_LDI || (op >= OP_ADD && op <= OP_SHR))
      z_nxt = (acc_nxt == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      b_reg     <= '0;
      ir        <= '0;
      pc        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (launch)
        pc <= '0;
      if (state == S_FETCH)
        ir <= mem[pc];
      if (state == S_EXEC) begin
        acc    <= acc_nxt;
        b_reg  <= b_nxt;
        flag_z <= z_nxt;
        flag_c <= c_nxt;
        pc     <= pc_nxt;
        if (out_en) begin
          out_data  <= acc;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule
